// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the 2-D convolution engine.
// Holds the control state enum, the accumulator width rule and a clog2 that never returns 0.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Worst-case |sum| of K*K products of an unsigned DW pixel and a signed WW weight.
    function automatic int acc_width(input int dw, input int ww, input int k);
        return dw + ww + 1 + clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffers plus the KxK sliding window; shifts one column per accepted pixel.
// Latency: window reflects a pixel on the edge it is accepted; holds whenever shift_en is low.
// Backpressure: none of its own, the caller gates shift_en with the input handshake.
module conv_line_buffer #(
    parameter int W  = 28,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [CW-1:0]         col,
    input  logic [DW-1:0]         pixel,
    output logic [K*K*DW-1:0]     window
);

    // rows[m] holds image row (current - 1 - m), indexed by column.
    logic [DW-1:0] rows [K-1][W];
    logic [DW-1:0] colv [K];
    logic [DW-1:0] win  [K][K];

    always_comb begin
        for (int i = 0; i < K - 1; i++) colv[i] = rows[K-2-i][col];
        colv[K-1] = pixel;
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            rows[0][col] <= pixel;
            for (int m = 1; m < K - 1; m++) rows[m][col] <= rows[m-1][col];
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
                win[i][K-1] <= colv[i];
            end
        end
    end

    // Row-major flattening: tap t = i*K + j, i = 0 is the oldest row.
    always_comb begin
        for (int t = 0; t < K * K; t++) window[t*DW +: DW] = win[t/K][t%K];
    end

endmodule

// File: rtl/conv2d_engine.sv
// Streaming KxK valid-mode convolution; optional ReLU output clamp via CONV2D_RELU_EN.
// Latency: out_valid 2 cycles after the pixel that completes a window is accepted.
// Backpressure: whole pipeline and in_ready hold while out_valid && !out_ready.
module conv2d_engine
    import conv_pkg::*;
#(
    parameter int H  = 28,
    parameter int W  = 28,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int WW = 8,
    localparam int ACC_W = acc_width(DW, WW, K),
    localparam int AW    = clog2(K * K)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_pixel,
    input  logic                    w_we,
    input  logic [AW-1:0]           w_addr,
    input  logic [WW-1:0]           w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int RW = clog2(H);
    localparam int CW = clog2(W);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);

    state_t state, state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept, stall, win_ok, frame_end;
    logic          v0, l0, v1, l1;
    logic signed [WW-1:0]    wt [K*K];
    logic [K*K*DW-1:0]       window;
    logic signed [ACC_W-1:0] sum_c, pe, we, s1_sum;

    assign accept    = in_valid && in_ready;
    assign stall     = out_valid && !out_ready;
    assign win_ok    = (row >= ROW_WIN) && (col >= COL_WIN);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        in_ready  = (state != DRAIN) && !stall;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (accept && frame_end) state_nxt = DRAIN;
            DRAIN:   if (out_valid && out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Coefficients are frozen for the whole frame once the engine leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < K * K; t++) wt[t] <= '0;
        end else if (w_we && state == IDLE && int'(w_addr) < K * K) begin
            wt[w_addr] <= w_data;
        end
    end

    conv_line_buffer #(.W(W), .K(K), .DW(DW), .CW(CW)) u_lb (
        .clk      (clk),
        .shift_en (accept),
        .col      (col),
        .pixel    (in_pixel),
        .window   (window)
    );

    always_comb begin
        sum_c = '0;
        pe    = '0;
        we    = '0;
        for (int t = 0; t < K * K; t++) begin
            pe    = $signed({{(ACC_W-DW){1'b0}}, window[t*DW +: DW]});
            we    = {{(ACC_W-WW){wt[t][WW-1]}}, wt[t]};
            sum_c = sum_c + pe * we;
        end
    end

    // Stage 0 is the window register; stage 1 the sum; stage 2 the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            l0        <= 1'b0;
            v1        <= 1'b0;
            l1        <= 1'b0;
            s1_sum    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            v0        <= accept && win_ok;
            l0        <= accept && frame_end;
            v1        <= v0;
            l1        <= l0;
            out_valid <= v1;
            out_last  <= l1;
            if (v0) s1_sum <= sum_c;
            if (v1) begin
`ifdef CONV2D_RELU_EN
                out_data <= s1_sum[ACC_W-1] ? '0 : s1_sum;
`else
                out_data <= s1_sum;
`endif
            end
        end
    end

endmodule

// File: doc/conv2d_engine.md
CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 Parameters SHALL be: H 28 image rows; W 28 image columns; K 3 kernel side; DW 8 pixel width, unsigned; WW 8 weight width, signed two's complement.
REQ-002 Ports SHALL be: clk in 1 clock; rst_n in 1 async active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be: in_valid in 1; in_ready out 1; in_pixel in DW, raster-order pixel stream.
REQ-004 Ports SHALL be: w_we in 1; w_addr in clog2(K*K), row-major tap index; w_data in WW, weight write port.
REQ-005 Ports SHALL be: out_valid out 1; out_ready in 1; out_data out ACC_W signed; out_last out 1, final output of frame.
REQ-006 Ports SHALL be: busy out 1, high in any state except IDLE.
REQ-007 ACC_W SHALL equal DW+WW+1+clog2(K*K).

Function
REQ-008 States SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN: first accepted pixel.
- RUN->DRAIN: H*W-th pixel accepted.
- DRAIN->IDLE: handshake of the out_last beat.
REQ-009 A pixel SHALL be accepted when in_valid && in_ready; in_ready SHALL be 0 in DRAIN and whenever out_valid && !out_ready.
REQ-010 Row/column counters SHALL advance per accepted pixel, wrap column at W-1 and row at H-1, and return to 0,0 at the frame end.
REQ-011 The K-1 most recent full rows SHALL be held in line buffers of depth W; the KxK window SHALL shift one column per accepted pixel.
REQ-012 A window SHALL be valid when row>=K-1 and col>=K-1, giving (H-K+1)*(W-K+1) outputs per frame, stride 1, no padding.
REQ-013 out_data SHALL be the signed sum over taps t of the zero-extended pixel[t] times weight[t], computed at full ACC_W width with no saturation.
REQ-014 Latency: out_valid SHALL assert exactly 2 cycles after acceptance of the pixel completing a valid window, given no stall.
REQ-015 Pipeline stages SHALL hold while out_valid && !out_ready; out_data SHALL stay stable until the handshake.
REQ-016 out_last SHALL be 1 only on the output for window row H-1, column W-1.
REQ-017 Weight writes SHALL take effect next cycle in IDLE and SHALL be ignored while busy.
REQ-018 Weights SHALL persist across frames; back-to-back frames SHALL need no weight reload.

Reset
REQ-019 Assertion of rst_n low SHALL immediately force the following, mid-frame included:
- state IDLE; counters 0; pipeline valid flags 0.
- out_valid 0, out_data 0, out_last 0, busy 0, in_ready 1.
REQ-020 Reset SHALL clear all weights to 0; line-buffer contents need not be reset.

Configuration
REQ-021 Macro CONV2D_RELU_EN:
- Defined: out_data SHALL be max(sum, 0).
- Undefined: out_data SHALL be the raw signed sum.
- Latency SHALL be the same in both cases.

Structure
REQ-022 Package conv_pkg SHALL hold the state enum, the ACC_W function and the clog2 helper.
REQ-023 Sub-module conv_line_buffer SHALL implement the K-1 row buffers and the KxK window register.

Verification
REQ-024 Setup H=W=5, K=3; all weights 1; all pixels 1 -> 9 outputs of value 9, out_last on the 9th, then busy falls.
REQ-025 Centre weight 1, others 0; pixels p=row*5+col -> outputs 6,7,8,11,12,13,16,17,18.
REQ-026 Same as REQ-025 with out_ready toggled 1-0 every cycle -> identical sequence; no duplicated or lost outputs; in_ready low during stalls.
REQ-027 w_we with w_data=5 while busy -> weights unchanged, outputs unchanged; rerun after IDLE uses 5.
REQ-028 All weights -1, pixels 2, with CONV2D_RELU_EN -> outputs 0; without the macro -> outputs -18.
REQ-029 rst_n low after 12 pixels -> out_valid 0 and busy 0 at once; a full new frame then yields a correct 9-output sequence.
